// File: rtl/kernel_load_ctrl.sv
// Load sequencer for the 49-entry kernel register bank: clears the bank, streams in
// KERNEL_SIZE bytes, then grants compute passes. Optional checksum: KERNEL_LOAD_CHECKSUM_EN.
module kernel_load_ctrl #(
  parameter int KERNEL_SIZE = 49,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             bank_rst_n,
  output logic             bank_we,
  output logic [7:0]       bank_wdata,
  output logic [CNT_W-1:0] load_count,
  output logic             kernel_valid,
  input  logic             compute_req,
  output logic             compute_grant,
  input  logic             compute_done,
  output logic             load_err,
  output logic [15:0]      kernel_sum
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_READY = 3'd3,
    ST_BUSY  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KERNEL_SIZE - 1);

  state_t           state_r, state_s;
  logic             clear_s, we_s, grant_s, err_s, valid_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             bank_rst_n_r, bank_we_r, kernel_valid_r, compute_grant_r, load_err_r;
  logic [7:0]       bank_wdata_r;

  assign s_ready       = (state_r == ST_LOAD);
  assign bank_rst_n    = bank_rst_n_r;
  assign bank_we       = bank_we_r;
  assign bank_wdata    = bank_wdata_r;
  assign load_count    = count_r;
  assign kernel_valid  = kernel_valid_r;
  assign compute_grant = compute_grant_r;
  assign load_err      = load_err_r;

  // Next-state and next-output decode; clear_s marks the edge that enters CLEAR.
  always_comb begin
    state_s = state_r;
    clear_s = 1'b0;
    we_s    = 1'b0;
    grant_s = 1'b0;
    err_s   = 1'b0;
    valid_s = kernel_valid_r;
    count_s = count_r;
    case (state_r)
      ST_IDLE: begin
        valid_s = 1'b0;
        if (load_start) begin
          state_s = ST_CLEAR;
          clear_s = 1'b1;
          count_s = {CNT_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_s = ST_LOAD;
        count_s = {CNT_W{1'b0}};
        valid_s = 1'b0;
      end
      ST_LOAD: begin
        // A restart discards the partial load, including any beat offered this cycle.
        if (load_start) begin
          state_s = ST_CLEAR;
          clear_s = 1'b1;
          count_s = {CNT_W{1'b0}};
          valid_s = 1'b0;
        end else if (s_valid) begin
          we_s    = 1'b1;
          count_s = count_r + CNT_W'(1);
          if (count_r == LAST_CNT) begin
            state_s = ST_READY;
            valid_s = 1'b1;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_READY: begin
        if (load_start) begin
          state_s = ST_CLEAR;
          clear_s = 1'b1;
          count_s = {CNT_W{1'b0}};
          valid_s = 1'b0;
        end else if (compute_req) begin
          state_s = ST_BUSY;
          grant_s = 1'b1;
        end else begin
          state_s = ST_READY;
        end
      end
      ST_BUSY: begin
        err_s = load_start;
        if (compute_done) begin
          state_s = ST_READY;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = {CNT_W{1'b0}};
        valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset holds the bank cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      count_r         <= {CNT_W{1'b0}};
      bank_rst_n_r    <= 1'b0;
      bank_we_r       <= 1'b0;
      bank_wdata_r    <= 8'd0;
      kernel_valid_r  <= 1'b0;
      compute_grant_r <= 1'b0;
      load_err_r      <= 1'b0;
    end else begin
      state_r         <= state_s;
      count_r         <= count_s;
      bank_rst_n_r    <= !clear_s;
      bank_we_r       <= we_s;
      bank_wdata_r    <= we_s ? s_data : bank_wdata_r;
      kernel_valid_r  <= valid_s;
      compute_grant_r <= grant_s;
      load_err_r      <= err_s;
    end
  end

`ifdef KERNEL_LOAD_CHECKSUM_EN
  logic [15:0] sum_r, sum_s;

  // Running wrap-around byte sum, tracking load_count.
  always_comb begin
    if (clear_s) begin
      sum_s = 16'd0;
    end else if (we_s) begin
      sum_s = sum_r + {8'd0, s_data};
    end else begin
      sum_s = sum_r;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r <= 16'd0;
    end else begin
      sum_r <= sum_s;
    end
  end

  assign kernel_sum = sum_r;
`else
  assign kernel_sum = 16'd0;
`endif

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// Directed self-checking bench for kernel_load_ctrl; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_kernel_load_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready;
  logic       bank_rst_n;
  logic       bank_we;
  logic [7:0] bank_wdata;
  logic [5:0] load_count;
  logic       kernel_valid;
  logic       compute_req = 1'b0;
  logic       compute_grant;
  logic       compute_done = 1'b0;
  logic       load_err;
  logic [15:0] kernel_sum;

  int n_cmp = 0;
  int n_err = 0;

`ifdef KERNEL_LOAD_CHECKSUM_EN
  localparam logic [15:0] SUM_SEQ = 16'd1225;
  localparam logic [15:0] SUM_FF  = 16'h30CF;
`else
  localparam logic [15:0] SUM_SEQ = 16'd0;
  localparam logic [15:0] SUM_FF  = 16'd0;
`endif

  kernel_load_ctrl #(.KERNEL_SIZE(49), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .bank_rst_n(bank_rst_n), .bank_we(bank_we), .bank_wdata(bank_wdata),
    .load_count(load_count), .kernel_valid(kernel_valid), .compute_req(compute_req),
    .compute_grant(compute_grant), .compute_done(compute_done), .load_err(load_err),
    .kernel_sum(kernel_sum)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int good;
    int pulses;
    int bad;
    int grants;

    // Reset values
    #12;
    check("rst_bank_rst_n", bank_rst_n, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_bank_we", bank_we, 0);
    check("rst_wdata", bank_wdata, 0);
    check("rst_load_count", load_count, 0);
    check("rst_kernel_valid", kernel_valid, 0);
    check("rst_grant", compute_grant, 0);
    check("rst_load_err", load_err, 0);
    check("rst_kernel_sum", kernel_sum, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_bank_rst_n", bank_rst_n, 1);
    check("idle_s_ready", s_ready, 0);

    // Basic load of bytes 1..49
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("clear_bank_rst_n", bank_rst_n, 0);
    check("clear_s_ready", s_ready, 0);
    step();
    check("load_bank_rst_n", bank_rst_n, 1);
    check("load_s_ready", s_ready, 1);
    good = 0;
    for (int i = 1; i <= 49; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
      if (bank_we === 1'b1 && bank_wdata === 8'(i)) good++;
    end
    s_valid = 1'b0;
    check("basic_writes_in_order", good, 49);
    check("basic_kernel_valid", kernel_valid, 1);
    check("basic_load_count", load_count, 49);
    check("basic_s_ready_after", s_ready, 0);
    check("basic_kernel_sum", kernel_sum, SUM_SEQ);
    s_valid = 1'b1;
    s_data  = 8'h55;
    step();
    s_valid = 1'b0;
    check("no_extra_write", bank_we, 0);
    check("count_holds_ready", load_count, 49);

    // Bubbles: 49 bytes of 0xFF, s_valid every other cycle
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("bub_clear_count", load_count, 0);
    check("bub_clear_valid", kernel_valid, 0);
    step();
    pulses = 0;
    bad = 0;
    for (int c = 0; c < 98; c++) begin
      s_valid = (c % 2 == 0);
      s_data  = 8'hFF;
      step();
      if (bank_we === 1'b1) pulses++;
      if (bank_we !== s_valid) bad++;
    end
    s_valid = 1'b0;
    check("bub_pulses", pulses, 49);
    check("bub_we_on_bubble", bad, 0);
    check("bub_kernel_valid", kernel_valid, 1);
    check("bub_kernel_sum", kernel_sum, SUM_FF);

    // Grant flow
    compute_req = 1'b1;
    step();
    check("grant_first", compute_grant, 1);
    grants = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (compute_grant === 1'b1) grants++;
    end
    check("grant_no_repeat", grants, 0);
    check("busy_kernel_valid", kernel_valid, 1);
    compute_req  = 1'b0;
    compute_done = 1'b1;
    step();
    compute_done = 1'b0;
    check("done_no_grant", compute_grant, 0);
    compute_req = 1'b1;
    step();
    compute_req = 1'b0;
    check("grant_again", compute_grant, 1);

    // Rejected reload in BUSY
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("rej_load_err", load_err, 1);
    check("rej_bank_rst_n", bank_rst_n, 1);
    check("rej_kernel_valid", kernel_valid, 1);
    step();
    check("rej_err_one_cycle", load_err, 0);
    load_start   = 1'b1;
    compute_done = 1'b1;
    step();
    load_start   = 1'b0;
    compute_done = 1'b0;
    check("rej_done_load_err", load_err, 1);
    check("rej_done_bank_rst_n", bank_rst_n, 1);
    compute_req = 1'b1;
    step();
    compute_req = 1'b0;
    check("rej_done_ready_grant", compute_grant, 1);
    compute_done = 1'b1;
    step();
    compute_done = 1'b0;

    // Priority: load_start beats compute_req in READY
    load_start  = 1'b1;
    compute_req = 1'b1;
    step();
    load_start  = 1'b0;
    compute_req = 1'b0;
    check("prio_no_grant", compute_grant, 0);
    check("prio_clear", bank_rst_n, 0);
    check("prio_valid_cleared", kernel_valid, 0);
    step();

    // Restart after 20 beats
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i + 100);
      step();
    end
    s_valid = 1'b0;
    check("restart_count20", load_count, 20);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("restart_clear_count", load_count, 0);
    check("restart_clear_bank", bank_rst_n, 0);
    step();
    for (int i = 0; i < 48; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
    end
    check("restart_48_not_valid", kernel_valid, 0);
    check("restart_48_count", load_count, 48);
    step();
    s_valid = 1'b0;
    check("restart_49_valid", kernel_valid, 1);

    // Async reset mid-load
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    step();
    for (int i = 0; i < 30; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
    end
    s_valid = 1'b0;
    check("mid_count30", load_count, 30);
    #2;
    rst = 1'b1;
    #1;
    check("arst_bank_rst_n", bank_rst_n, 0);
    check("arst_kernel_valid", kernel_valid, 0);
    check("arst_load_count", load_count, 0);
    check("arst_bank_we", bank_we, 0);
    check("arst_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("arst_rel_bank_rst_n", bank_rst_n, 1);
    check("arst_idle_s_ready", s_ready, 0);
    compute_req = 1'b1;
    step();
    compute_req = 1'b0;
    check("arst_idle_no_grant", compute_grant, 0);
    check("arst_idle_valid", kernel_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
